// File: rtl/debug_slave_pkg.sv
// Shared types and defaults for the debug slave system-clock command path.
// Provides the command bundle type and default widths for the JTAG scan data.
package debug_slave_pkg;

  localparam int SR_W_DEF    = 38;
  localparam int IR_W_DEF    = 2;
  localparam int ACT_BIT_DEF = 34;
  localparam int NUM_CH      = 2**IR_W_DEF;

  typedef struct packed {
    logic [IR_W_DEF-1:0] ir;
    logic [SR_W_DEF-1:0] data;
  } cmd_t;

endpackage

// File: rtl/debug_slave_sysclk_cmdq_sync.sv
// Multi-flop synchroniser with a one-cycle rising-edge pulse output.
// Ports: clk, reset_n, async_i (async level), pulse_o (one clk cycle per rise).
module debug_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/debug_slave_sysclk_cmdq.sv
// System-clock command receiver: syncs update-IR/DR, queues {ir,sr} commands.
// Ports: vs_uir/vs_udr/ir_in/sr in; cmd_* handshake, take_* pulses, overflow out.
module debug_slave_sysclk_cmdq
  import debug_slave_pkg::*;
#(
  parameter int SR_W        = SR_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int ACT_BIT     = ACT_BIT_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     vs_uir,
  input  logic                     vs_udr,
  input  logic [IR_W-1:0]          ir_in,
  input  logic [SR_W-1:0]          sr,
  input  logic                     cmd_ready,
  input  logic                     clear_overflow,
  output logic                     cmd_valid,
  output logic [IR_W-1:0]          cmd_ir,
  output logic [SR_W-1:0]          jdo,
  output logic [2**IR_W-1:0]       take_action,
  output logic [2**IR_W-1:0]       take_no_action,
  output logic                     cmd_overflow,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int NCH = 2**IR_W;
  localparam int PW  = $clog2(DEPTH);
  localparam logic [NCH-1:0] ONE_CH = NCH'(1);

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] data;
  } entry_t;

  logic uir_evt, udr_evt;

  debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (vs_uir),
    .pulse_o (uir_evt)
  );

  debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (vs_udr),
    .pulse_o (udr_evt)
  );

  logic [IR_W-1:0] ir_reg_q, ir_reg_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  entry_t          mem_q [DEPTH];
  entry_t          head;
  logic            full, pop, push_ok, drop;

  assign head      = mem_q[rd_ptr_q];
  assign cmd_valid = (cnt_q != '0);
  assign full      = (cnt_q == (PW+1)'(DEPTH));
  assign pop       = cmd_valid & cmd_ready;
  // A pop frees the slot on the same edge, so a full queue can still accept.
  assign push_ok   = udr_evt & (~full | pop);
  assign drop      = udr_evt & full & ~pop;

  assign cmd_ir = cmd_valid ? head.ir : '0;
  assign jdo    = cmd_valid ? head.data : '0;

  assign take_action    = (pop &  head.data[ACT_BIT]) ? (ONE_CH << head.ir) : '0;
  assign take_no_action = (pop & ~head.data[ACT_BIT]) ? (ONE_CH << head.ir) : '0;

  assign cmd_overflow = ovf_q;
  assign fill_level   = cnt_q;

  always_comb begin
    ir_reg_d = uir_evt ? ir_in : ir_reg_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok && !pop)
      cnt_d = cnt_q + (PW+1)'(1);
    else if (pop && !push_ok)
      cnt_d = cnt_q - (PW+1)'(1);
    // A drop in the same cycle as a clear keeps the flag set.
    ovf_d = drop ? 1'b1 : (clear_overflow ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_reg_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ir_reg_q <= ir_reg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= '{ir: ir_reg_q, data: sr};
  end

endmodule

// File: tb/tb_debug_slave_sysclk_cmdq.sv
// Directed self-checking bench for debug_slave_sysclk_cmdq.
// Drives and samples on the falling clk edge.
module tb_debug_slave_sysclk_cmdq;
  import debug_slave_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vs_uir = 1'b0;
  logic        vs_udr = 1'b0;
  logic [1:0]  ir_in = '0;
  logic [37:0] sr = '0;
  logic        cmd_ready = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        cmd_valid;
  logic [1:0]  cmd_ir;
  logic [37:0] jdo;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic        cmd_overflow;
  logic [2:0]  fill_level;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  debug_slave_sysclk_cmdq #(
    .SR_W(38), .IR_W(2), .ACT_BIT(34), .SYNC_STAGES(2), .DEPTH(4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vs_uir         (vs_uir),
    .vs_udr         (vs_udr),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_ready      (cmd_ready),
    .clear_overflow (clear_overflow),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .cmd_overflow   (cmd_overflow),
    .fill_level     (fill_level)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [37:0] mk(input int i);
    logic [37:0] d;
    d = 38'(i) | 38'h100;
    if (i % 2 == 1) d = d | 38'h04_0000_0000;
    return d;
  endfunction

  task automatic send_ir(input logic [1:0] v);
    ir_in = v;
    vs_uir = 1'b1;
    repeat (3) tick();
    vs_uir = 1'b0;
    repeat (3) tick();
  endtask

  task automatic strobe(input logic [37:0] d);
    sr = d;
    vs_udr = 1'b1;
    repeat (3) tick();
    vs_udr = 1'b0;
    repeat (3) tick();
  endtask

  // Expects a pop this cycle (cmd_ready already high), then advances.
  task automatic pop_expect(input cmd_t c);
    logic [3:0] oh;
    oh = 4'b0001 << c.ir;
    #1;
    chk("pop_valid", 64'(cmd_valid), 64'd1);
    chk("pop_jdo", 64'(jdo), 64'(c.data));
    chk("pop_ir", 64'(cmd_ir), 64'(c.ir));
    chk("pop_ta", 64'(take_action), 64'(c.data[34] ? oh : 4'b0));
    chk("pop_tna", 64'(take_no_action), 64'(c.data[34] ? 4'b0 : oh));
    tick();
  endtask

  task automatic run_single(input logic [1:0] ir, input logic [37:0] d);
    int first_k, n_valid, n_pulse;
    logic [37:0] s_jdo;
    logic [1:0]  s_ir;
    logic [3:0]  s_ta, s_tna, oh;
    first_k = -1; n_valid = 0; n_pulse = 0;
    s_jdo = '0; s_ir = '0; s_ta = '0; s_tna = '0;
    oh = 4'b0001 << ir;
    send_ir(ir);
    cmd_ready = 1'b1;
    sr = d;
    vs_udr = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      #1;
      if (cmd_valid) begin
        n_valid++;
        if (first_k < 0) begin
          first_k = k;
          s_jdo = jdo; s_ir = cmd_ir;
          s_ta = take_action; s_tna = take_no_action;
        end
      end
      if (take_action != 0 || take_no_action != 0) n_pulse++;
      if (k == 3) vs_udr = 1'b0;
    end
    chk("single_lat", 64'(first_k), 64'd3);
    chk("single_nvalid", 64'(n_valid), 64'd1);
    chk("single_npulse", 64'(n_pulse), 64'd1);
    chk("single_jdo", 64'(s_jdo), 64'(d));
    chk("single_ir", 64'(s_ir), 64'(ir));
    chk("single_ta", 64'(s_ta), 64'(d[34] ? oh : 4'b0));
    chk("single_tna", 64'(s_tna), 64'(d[34] ? 4'b0 : oh));
    cmd_ready = 1'b0;
    tick();
  endtask

  initial begin
    cmd_t c;
    repeat (2) tick();
    #1;
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_ovf", 64'(cmd_overflow), 64'd0);
    chk("rst_jdo", 64'(jdo), 64'd0);
    chk("rst_take", 64'({take_action, take_no_action, cmd_ir}), 64'd0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();

    run_single(2'd1, 38'h04_0000_1234);
    run_single(2'd3, 38'h00_0000_5678);

    // Backpressure: five strobes into a four-deep queue.
    send_ir(2'd2);
    for (int i = 1; i <= 5; i++) strobe(mk(i));
    #1;
    chk("bp_fill", 64'(fill_level), 64'd4);
    chk("bp_ovf", 64'(cmd_overflow), 64'd1);
    tick();
    cmd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      c.ir = 2'd2; c.data = mk(i);
      pop_expect(c);
    end
    cmd_ready = 1'b0;
    #1;
    chk("bp_drain_fill", 64'(fill_level), 64'd0);
    chk("bp_drain_valid", 64'(cmd_valid), 64'd0);
    tick();

    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    #1;
    chk("clr_ovf", 64'(cmd_overflow), 64'd0);
    tick();

    // Full queue with a push landing on the same edge as a pop.
    for (int i = 11; i <= 14; i++) strobe(mk(i));
    sr = mk(15);
    vs_udr = 1'b1;
    repeat (2) tick();
    cmd_ready = 1'b1;
    c.ir = 2'd2; c.data = mk(11);
    pop_expect(c);
    cmd_ready = 1'b0;
    vs_udr = 1'b0;
    #1;
    chk("fullpop_fill", 64'(fill_level), 64'd4);
    chk("fullpop_ovf", 64'(cmd_overflow), 64'd0);
    repeat (3) tick();
    cmd_ready = 1'b1;
    for (int i = 12; i <= 15; i++) begin
      c.ir = 2'd2; c.data = mk(i);
      pop_expect(c);
    end
    cmd_ready = 1'b0;
    #1;
    chk("fullpop_drain", 64'(fill_level), 64'd0);
    tick();

    // Clear coinciding with a dropped push.
    for (int i = 21; i <= 24; i++) strobe(mk(i));
    sr = mk(25);
    vs_udr = 1'b1;
    repeat (2) tick();
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    vs_udr = 1'b0;
    #1;
    chk("race_ovf", 64'(cmd_overflow), 64'd1);
    chk("race_fill", 64'(fill_level), 64'd4);
    repeat (3) tick();
    cmd_ready = 1'b1;
    c.ir = 2'd2; c.data = mk(21);
    pop_expect(c);
    cmd_ready = 1'b0;
    #1;
    chk("pre_rst_fill", 64'(fill_level), 64'd3);

    // Asynchronous reset between clock edges with three entries queued.
    tick();
    cmd_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_fill", 64'(fill_level), 64'd0);
    chk("arst_valid", 64'(cmd_valid), 64'd0);
    chk("arst_ovf", 64'(cmd_overflow), 64'd0);
    chk("arst_jdo", 64'(jdo), 64'd0);
    chk("arst_take", 64'({take_action, take_no_action}), 64'd0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("post_rst_quiet",
          64'({cmd_valid, take_action, take_no_action}), 64'd0);
      tick();
    end
    cmd_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
